// File: rtl/golden_nonce_uart_tx_if.sv
// Golden-nonce strobe bundle from the hash core to the UART return path.
interface golden_nonce_uart_tx_if;
  logic [31:0] golden_nonce;
  logic        golden_nonce_match;

  modport master (
    output golden_nonce,
    output golden_nonce_match
  );

  modport slave (
    input golden_nonce,
    input golden_nonce_match
  );
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// Queues golden-nonce strobes and sends each nonce as four 8N1 bytes, MSB byte first.
// Optional macro GOLDEN_NONCE_DEDUP_EN drops a strobe repeating the last pushed nonce.
module golden_nonce_uart_tx #(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 2
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  golden_nonce_uart_tx_if.slave nonce,
  output logic                 txd,
  output logic                 tx_busy,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  state_t             state_n;
  logic [15:0]        timer;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic [31:0]        shreg;
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               tick;
  logic               full;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               drop;

  assign tick    = (timer == BIT_LAST);
  assign full    = (fifo_count == FULL_CNT);
  assign pop     = (state == IDLE) && (fifo_count != '0);
  assign tx_busy = (state != IDLE) || (fifo_count != '0);

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [31:0] last_pushed;
  logic        last_valid;

  assign push_req = nonce.golden_nonce_match &&
                    !(last_valid && (nonce.golden_nonce == last_pushed));

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      last_pushed <= '0;
      last_valid  <= 1'b0;
    end else if (push) begin
      last_pushed <= nonce.golden_nonce;
      last_valid  <= 1'b1;
    end
  end
`else
  assign push_req = nonce.golden_nonce_match;
`endif

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_ff @(posedge hash_clk) begin
    if (push) mem[wr_ptr] <= nonce.golden_nonce;
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    txd     = 1'b1;
    case (state)
      IDLE:  if (pop) state_n = START;
      START: begin
        txd = 1'b0;
        if (tick) state_n = DATA;
      end
      DATA: begin
        txd = shreg[{2'b11, bit_idx}];
        if (tick && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (tick) state_n = (byte_idx == 2'd3) ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end

  // Current byte always sits in shreg[31:24]; shift after each stop bit.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      if (state == IDLE) timer <= '0;
      else               timer <= tick ? 16'd0 : timer + 16'd1;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
          end
        end
        START: if (tick) bit_idx <= '0;
        DATA:  if (tick) bit_idx <= bit_idx + 3'd1;
        STOP: begin
          if (tick && byte_idx != 2'd3) begin
            byte_idx <= byte_idx + 2'd1;
            shreg    <= {shreg[23:0], 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Directed bench for golden_nonce_uart_tx with BAUD_DIV=4, FIFO_AW=2.
// A UART receiver task samples txd mid-bit to rebuild each nonce.
module tb_golden_nonce_uart_tx;

  localparam int BD = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          txd;
  logic          tx_busy;
  logic [AW:0]   fifo_count;
  logic          overflow;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  golden_nonce_uart_tx_if nif ();

  golden_nonce_uart_tx #(
    .BAUD_DIV(BD),
    .FIFO_AW (AW)
  ) dut (
    .hash_clk  (clk),
    .reset     (rst),
    .nonce     (nif.slave),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int t;
    b  = '0;
    ok = 1'b1;
    t  = 0;
    while (txd !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (BD / 2) @(negedge clk);
    if (txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = txd;
    end
    repeat (BD) @(negedge clk);
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_nonce(output logic [31:0] n, output bit ok);
    logic [7:0] b;
    bit         bok;
    n  = '0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte(b, bok);
      if (!bok) ok = 1'b0;
      n = {n[23:0], b};
    end
  endtask

  task automatic wait_idle(output bit ok);
    int t;
    t = 0;
    while (tx_busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (tx_busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nif.golden_nonce = '0;
    nif.golden_nonce_match = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: txd=%b busy=%b cnt=%0d ovf=%b, required 1 0 0 0",
               txd, tx_busy, fifo_count, overflow);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: txd=%b busy=%b, required 1 0", txd, tx_busy);
    end
  endtask

  task automatic test_single();
    logic [31:0] n;
    bit          ok;
    int          c0;
    nif.golden_nonce = 32'hA5C3_0F81;
    nif.golden_nonce_match = 1'b1;
    @(negedge clk);
    nif.golden_nonce_match = 1'b0;
    nif.golden_nonce = 32'hDEAD_BEEF;
    checks++;
    if (fifo_count !== 3'd1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_queued: cnt=%0d txd=%b, required 1 1", fifo_count, txd);
    end
    @(negedge clk);
    c0 = cyc;
    checks++;
    if (txd !== 1'b0 || fifo_count !== 3'd0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: txd=%b cnt=%0d busy=%b, required 0 0 1",
               txd, fifo_count, tx_busy);
    end
    rx_nonce(n, ok);
    checks++;
    if (!ok || n !== 32'hA5C3_0F81) begin
      errors++;
      $display("FAIL single_nonce: got %h framing_ok=%b, required a5c30f81", n, ok);
    end
    wait_idle(ok);
    checks++;
    if (!ok || (cyc - c0) != 160) begin
      errors++;
      $display("FAIL single_frame_len: %0d cycles, required 160", cyc - c0);
    end
  endtask

  task automatic test_burst5();
    logic [31:0] n;
    bit          ok;
    int          peak;
    peak = 0;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          nif.golden_nonce = 32'(i);
          nif.golden_nonce_match = 1'b1;
          @(negedge clk);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        nif.golden_nonce_match = 1'b0;
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          rx_nonce(n, ok);
          checks++;
          if (!ok || n !== 32'(i) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst5_nonce%0d: got %h ovf=%b ok=%b, required %h ovf=0",
                     i, n, overflow, ok, 32'(i));
          end
        end
      end
    join
    checks++;
    if (peak != 4) begin
      errors++;
      $display("FAIL burst5_peak: got %0d, required 4", peak);
    end
    wait_idle(ok);
    checks++;
    if (!ok || fifo_count !== '0) begin
      errors++;
      $display("FAIL burst5_idle: busy=%b cnt=%0d, required 0 0", tx_busy, fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] n;
    bit          ok;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          nif.golden_nonce = 32'(i);
          nif.golden_nonce_match = 1'b1;
          @(negedge clk);
        end
        nif.golden_nonce_match = 1'b0;
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          rx_nonce(n, ok);
          checks++;
          if (!ok || n !== 32'(i) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_nonce%0d: got %h ovf=%b ok=%b, required %h ovf=1",
                     i, n, overflow, ok, 32'(i));
          end
        end
      end
    join
    wait_idle(ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || tx_busy !== 1'b0 || txd !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_no_sixth: busy=%b txd=%b ovf=%b, required 0 1 1",
               tx_busy, txd, overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit bad;
    nif.golden_nonce = 32'h5A00_FF33;
    nif.golden_nonce_match = 1'b1;
    @(negedge clk);
    nif.golden_nonce = 32'h1111_1111;
    @(negedge clk);
    nif.golden_nonce_match = 1'b0;
    repeat (57) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || fifo_count !== 3'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: txd=%b cnt=%0d ovf=%b, required 0 1 1",
               txd, fifo_count, overflow);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1 || fifo_count !== '0 || overflow !== 1'b0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: txd=%b cnt=%0d ovf=%b busy=%b, required 1 0 0 0",
               txd, fifo_count, overflow, tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_quiet: line activity after release, required idle");
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] n;
    logic [31:0] exp_q [5];
    bit          ok;
    exp_q = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
              32'hC0DE_0004, 32'hC0DE_00FF};
    for (int i = 0; i < 5; i++) begin
      nif.golden_nonce = 32'hC0DE_0000 + 32'(i);
      nif.golden_nonce_match = 1'b1;
      @(negedge clk);
    end
    nif.golden_nonce_match = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_fill: cnt=%0d ovf=%b, required 4 0", fifo_count, overflow);
    end
    repeat (157) @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || txd !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_pre: cnt=%0d txd=%b busy=%b, required 4 1 1",
               fifo_count, txd, tx_busy);
    end
    nif.golden_nonce = 32'hC0DE_00FF;
    nif.golden_nonce_match = 1'b1;
    @(negedge clk);
    nif.golden_nonce_match = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || txd !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_edge: cnt=%0d ovf=%b txd=%b, required 4 0 0",
               fifo_count, overflow, txd);
    end
    for (int i = 0; i < 5; i++) begin
      rx_nonce(n, ok);
      checks++;
      if (!ok || n !== exp_q[i]) begin
        errors++;
        $display("FAIL fullpop_nonce%0d: got %h ok=%b, required %h", i, n, ok, exp_q[i]);
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_end: busy=%b ovf=%b, required 0 0", tx_busy, overflow);
    end
  endtask

  task automatic test_dedup();
    logic [31:0] n;
    logic [31:0] exp_q [3];
    bit          ok;
    int          n_exp;
`ifdef GOLDEN_NONCE_DEDUP_EN
    exp_q = '{32'h1234_5678, 32'h1234_5679, 32'h0};
    n_exp = 2;
`else
    exp_q = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5679};
    n_exp = 3;
`endif
    fork
      begin
        nif.golden_nonce = 32'h1234_5678;
        nif.golden_nonce_match = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nif.golden_nonce = 32'h1234_5679;
        @(negedge clk);
        nif.golden_nonce_match = 1'b0;
      end
      begin
        for (int i = 0; i < n_exp; i++) begin
          rx_nonce(n, ok);
          checks++;
          if (!ok || n !== exp_q[i]) begin
            errors++;
            $display("FAIL dedup_nonce%0d: got %h ok=%b, required %h", i, n, ok, exp_q[i]);
          end
        end
      end
    join
    wait_idle(ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || tx_busy !== 1'b0 || txd !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dedup_end: busy=%b txd=%b ovf=%b, required 0 1 0",
               tx_busy, txd, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst5();
    test_overflow();
    test_reset_mid_frame();
    test_full_pop();
    test_dedup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
Return path from the hashing core to the host. Captures each one-cycle golden-nonce strobe into a small FIFO. Serialises each queued nonce as four 8N1 UART bytes on the host serial line. Sits in the hash_clk domain, directly downstream of the hash core's golden_nonce / golden_nonce_match outputs. It absorbs bursts of matches while the slow serial line drains.

Parameters:
BAUD_DIV, 868, hash_clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW nonces

Ports:
hash_clk  in  1  sole clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state immediately
golden_nonce  in  32  nonce value, valid when golden_nonce_match is high
golden_nonce_match  in  1  one-cycle strobe; capture golden_nonce this cycle
txd  out  1  UART serial output, idle high
tx_busy  out  1  high while FSM not IDLE or FIFO non-empty
fifo_count  out  FIFO_AW+1  number of nonces queued (not including the one being shifted)
overflow  out  1  sticky: a nonce was dropped because the FIFO was full

Behaviour:
- One clock (hash_clk). Reset is asynchronous, active-high, port named reset. While reset is high: txd=1, tx_busy=0, fifo_count=0, overflow=0, FSM=IDLE, bit timer=0, FIFO pointers=0.
- Push: on an edge where golden_nonce_match=1, golden_nonce is written to the FIFO tail and fifo_count increments.
- Push when full and no pop on the same edge: the nonce is dropped, overflow is set, and FIFO contents are unchanged. overflow clears only on reset.
- Push when full with a pop on the same edge: the push is accepted, and fifo_count stays at its full value.
- Push and pop on the same edge when not full: fifo_count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
- Bit timer counts 0..BAUD_DIV-1. Each state holds its txd level for exactly BAUD_DIV cycles per bit.
- IDLE: txd=1. If the FIFO is non-empty, the next edge pops the head into a 32-bit shift register, sets byte_idx=0, and moves to START.
- Latency: match sampled at edge k on an empty, idle block → fifo_count=1 after edge k → pop and txd=0 after edge k+1.
- START: txd=0 for BAUD_DIV cycles, then DATA with bit_idx=0.
- DATA: txd = current byte bit[bit_idx], LSB first, for 8 bits, then STOP.
- Byte order: most-significant byte first. Byte 0 = nonce[31:24], byte 3 = nonce[7:0].
- STOP: txd=1 for BAUD_DIV cycles.
  - If byte_idx<3: byte_idx increments and the FSM returns to START (no extra idle gap).
  - If byte_idx==3: go to IDLE. If the FIFO is non-empty on arrival in IDLE, the pop happens on the following edge, giving at most 1 extra idle cycle between nonces.
- Frame length: 4 × 10 × BAUD_DIV cycles per nonce.
- tx_busy is combinational from state and fifo_count: 1 whenever the FSM≠IDLE or fifo_count≠0.
- Arithmetic: FIFO pointers are FIFO_AW bits and wrap modulo depth. fifo_count is FIFO_AW+1 bits and never exceeds 2**FIFO_AW. The bit timer is 16 bits.
- Reset mid-frame: the frame is abandoned. txd returns to 1 asynchronously and no partial byte resumes after reset release.
- golden_nonce is sampled only on strobe edges. The value at other times is ignored.

Optional Feature:
Macro GOLDEN_NONCE_DEDUP_EN.
- Defined: a 32-bit last_pushed register plus a valid flag, both cleared by reset. A strobe whose golden_nonce equals last_pushed (with valid set) is discarded: no push, no overflow. This suppresses duplicate reports of the same nonce.
- Not defined: every strobe is pushed per the rules above; the register and comparator are absent.

Test Plan:
- BAUD_DIV=4, single strobe with golden_nonce=32'hA5C3_0F81 → txd falls 2 edges after the strobe edge; the line carries bytes A5, C3, 0F, 81, each framed with start 0 / LSB first / stop 1 and bit width 4 cycles. Total 160 cycles, then tx_busy=0.
- FIFO_AW=2, five strobes on consecutive cycles (values 1..5) → bytes for 1, 2, 3, 4, 5 transmitted in order, since nonce 1 pops before strobe 5. overflow=0 and fifo_count peaks at 4.
- Six strobes on consecutive cycles → nonce 6 dropped, overflow=1 and stays 1 through the remaining transmissions; only 1..5 appear on txd.
- Assert reset during bit 3 of byte 1 → txd=1 in the same cycle, fifo_count=0, overflow=0. After release with no strobes, txd stays 1 and tx_busy=0.
- Strobe arriving in the same cycle as a pop while full → fifo_count unchanged at 4, no overflow, and the new nonce is transmitted last.
- GOLDEN_NONCE_DEDUP_EN defined, strobes 32'h1234_5678 twice, then 32'h1234_5679 → only two nonces transmitted, overflow=0. Macro undefined → three nonces transmitted.
